// File: rtl/pitch_height_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pitch_height_tracker
// Description : Mic-to-height pitch path. Decimates the mic ADC stream into
//               sample ticks and packs N_POINTS-sample frames for an external
//               FFT (start/done handshake). Scans the magnitude bins for the
//               peak, maps it to a sprite height and optionally smooths the
//               height with a power-of-two moving average. Frames arriving
//               while the FFT path is busy are dropped and counted.
// Ports       : clk, reset (sync, active-high)
//               mic_data      - unsigned ADC sample
//               smooth_en     - 1: averaged height, 0: raw height
//               fft_in        - latched frame, element 0 = newest sample
//               fft_start     - one-cycle pulse when a frame is latched
//               fft_status    - FFT done level (rising edge = results valid)
//               fft_out       - bin magnitudes 0..N_POINTS/2-1
//               height        - current height
//               height_valid  - one-cycle pulse when height updates
//               peak_bin      - last winning bin
//               overrun_cnt   - dropped-frame count, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module pitch_height_tracker #(
    parameter int SAMPLE_DIV  = 50000,
    parameter int N_POINTS    = 64,
    parameter int SAMPLE_W    = 12,
    parameter int FFT_W       = 16,
    parameter int DROP_LSB    = 5,
    parameter int FRAC_BITS   = 8,
    parameter int HEIGHT_BASE = 100,
    parameter int HEIGHT_STEP = 9,
    parameter int AVG_LOG2    = 4,
    parameter int MIN_MAG     = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [SAMPLE_W-1:0]                   mic_data,
    input  logic                                  smooth_en,
    output logic [N_POINTS-1:0][FFT_W-1:0]        fft_in,
    output logic                                  fft_start,
    input  logic                                  fft_status,
    input  logic [N_POINTS/2-1:0][FFT_W-1:0]      fft_out,
    output logic [9:0]                            height,
    output logic                                  height_valid,
    output logic [$clog2(N_POINTS)-2:0]           peak_bin,
    output logic [7:0]                            overrun_cnt
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W  = $clog2(N_POINTS);
    localparam int IDX_W  = $clog2(N_POINTS) - 1;
    localparam int HIST_N = 1 << AVG_LOG2;
    localparam int SUM_W  = 10 + AVG_LOG2;
    localparam int PACK_W = SAMPLE_W + 1 + FRAC_BITS;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N_POINTS - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_POINTS / 2 - 1);

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_WAIT_FFT = 2'd1,
        S_SCAN     = 2'd2,
        S_UPDATE   = 2'd3
    } state_t;

    state_t                          r_state, w_state_next;
    logic [DIV_W-1:0]                r_div;
    logic                            r_tick;
    logic [CNT_W-1:0]                r_sample_cnt;
    logic [N_POINTS-1:0][FFT_W-1:0]  r_shift;
    logic                            r_prev_status;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                r_best;
    logic [FFT_W-1:0]                r_max;
    logic [HIST_N-1:0][9:0]          r_hist;
    logic [SUM_W-1:0]                r_sum;

    logic [PACK_W-1:0]               w_pack;
    logic [FFT_W-1:0]                w_word;
    logic [N_POINTS-1:0][FFT_W-1:0]  w_shift_next;
    logic                            w_boundary;
    logic                            w_done;
    logic                            w_silent;
    logic [31:0]                     w_raw_full;
    logic [9:0]                      w_raw;
    logic [SUM_W-1:0]                w_sum_next;
    logic [9:0]                      w_avg;

    // Packed sample: drop mic LSBs, then append fractional zero bits.
    assign w_pack       = (PACK_W'({1'b0, mic_data}) >> DROP_LSB) << FRAC_BITS;
    assign w_word       = FFT_W'(w_pack);
    assign w_shift_next = {r_shift[N_POINTS-2:0], w_word};

    // The frame is complete on the tick that brings in its last sample; the
    // latched frame includes that sample.
    assign w_boundary   = r_tick && (r_sample_cnt == c_cnt_last);
    assign w_done       = fft_status & ~r_prev_status;

    // Signed compare keeps MIN_MAG = 0 well-defined (never silent).
    assign w_silent     = (int'({1'b0, r_max}) < MIN_MAG);

    always_comb begin
        w_raw_full = 32'(HEIGHT_BASE);
        if (!w_silent && (r_best != '0)) begin
            w_raw_full = 32'(HEIGHT_BASE) + 32'(HEIGHT_STEP) * 32'(r_best);
        end
        w_raw = (w_raw_full > 32'd1023) ? 10'd1023 : w_raw_full[9:0];
    end

    assign w_sum_next = r_sum - SUM_W'(r_hist[HIST_N-1]) + SUM_W'(w_raw);
    assign w_avg      = 10'(w_sum_next >> AVG_LOG2);

    // Sample-tick divider; the tick is registered one cycle after the
    // counter reaches its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= (r_div == c_div_last) ? '0 : r_div + DIV_W'(1);
            r_tick <= (r_div == c_div_last);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:     if (w_boundary)           w_state_next = S_WAIT_FFT;
            S_WAIT_FFT: if (w_done)               w_state_next = S_SCAN;
            S_SCAN:     if (r_idx == c_idx_last)  w_state_next = S_UPDATE;
            S_UPDATE:                             w_state_next = S_FILL;
            default:                              w_state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_cnt  <= '0;
            r_shift       <= '0;
            r_prev_status <= 1'b0;
            r_idx         <= '0;
            r_best        <= '0;
            r_max         <= '0;
            r_hist        <= '0;
            r_sum         <= '0;
            fft_in        <= '0;
            fft_start     <= 1'b0;
            height        <= '0;
            height_valid  <= 1'b0;
            peak_bin      <= '0;
            overrun_cnt   <= '0;
        end else begin
            fft_start     <= 1'b0;
            height_valid  <= 1'b0;
            r_prev_status <= fft_status;

            // Sampling runs in every state and never stalls.
            if (r_tick) begin
                r_shift      <= w_shift_next;
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end

            if (w_boundary) begin
                if (r_state == S_FILL) begin
                    fft_in    <= w_shift_next;
                    fft_start <= 1'b1;
                end else if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end

            case (r_state)
                S_WAIT_FFT: begin
                    if (w_done) begin
                        r_idx  <= IDX_W'(1);
                        r_max  <= fft_out[0];
                        r_best <= '0;
                    end
                end
                S_SCAN: begin
                    // Strict compare: ties stay with the lower bin.
                    if (fft_out[r_idx] > r_max) begin
                        r_max  <= fft_out[r_idx];
                        r_best <= r_idx;
                    end
                    r_idx <= r_idx + IDX_W'(1);
                end
                S_UPDATE: begin
                    for (int i = HIST_N - 1; i > 0; i--) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                    r_hist[0]    <= w_raw;
                    r_sum        <= w_sum_next;
                    height       <= smooth_en ? w_avg : w_raw;
                    peak_bin     <= r_best;
                    height_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pitch_height_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pitch_height_tracker
// Description : Directed self-checking bench for pitch_height_tracker. Two
//               instances share all stimulus: one with MIN_MAG=0 and one with
//               MIN_MAG=50 (silence threshold above the test peak).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pitch_height_tracker;

    logic                  clk;
    logic                  reset;
    logic [11:0]           mic_data;
    logic                  smooth_en;
    logic                  fft_status;
    logic [3:0][15:0]      fft_out;

    logic [7:0][15:0]      fft_in,       s_fft_in;
    logic                  fft_start,    s_fft_start;
    logic [9:0]            height,       s_height;
    logic                  height_valid, s_height_valid;
    logic [1:0]            peak_bin,     s_peak_bin;
    logic [7:0]            overrun_cnt,  s_overrun_cnt;

    int passed = 0;
    int total  = 0;

    pitch_height_tracker #(
        .SAMPLE_DIV(4), .N_POINTS(8), .AVG_LOG2(2), .MIN_MAG(0)
    ) dut (
        .clk(clk), .reset(reset), .mic_data(mic_data), .smooth_en(smooth_en),
        .fft_in(fft_in), .fft_start(fft_start), .fft_status(fft_status),
        .fft_out(fft_out), .height(height), .height_valid(height_valid),
        .peak_bin(peak_bin), .overrun_cnt(overrun_cnt)
    );

    pitch_height_tracker #(
        .SAMPLE_DIV(4), .N_POINTS(8), .AVG_LOG2(2), .MIN_MAG(50)
    ) dut_sil (
        .clk(clk), .reset(reset), .mic_data(mic_data), .smooth_en(smooth_en),
        .fft_in(s_fft_in), .fft_start(s_fft_start), .fft_status(fft_status),
        .fft_out(fft_out), .height(s_height), .height_valid(s_height_valid),
        .peak_bin(s_peak_bin), .overrun_cnt(s_overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output int n, output bit found);
        n = 0;
        do begin
            step();
            n++;
        end while (!fft_start && n < budget);
        found = fft_start;
    endtask

    task automatic wait_valid(input int budget, output bit found);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!height_valid && n < budget);
        found = height_valid;
    endtask

    initial begin
        int               n;
        bit               found;
        bit               pulse_seen;
        logic [7:0][15:0] exp_frame;
        int               exp_smooth [4];
        int               exp_sil    [4];

        exp_smooth = '{29, 59, 88, 118};
        exp_sil    = '{25, 50, 75, 100};
        for (int i = 0; i < 8; i++) exp_frame[i] = 16'h7F00;

        reset      = 1'b1;
        mic_data   = 12'hFFF;
        smooth_en  = 1'b0;
        fft_status = 1'b0;
        fft_out[0] = 16'd10;
        fft_out[1] = 16'd3;
        fft_out[2] = 16'd40;
        fft_out[3] = 16'd40;

        // Reset state
        repeat (3) step();
        check("rst_height",       height,         0);
        check("rst_height_valid", height_valid,   0);
        check("rst_peak_bin",     peak_bin,       0);
        check("rst_overrun",      overrun_cnt,    0);
        check("rst_fft_start",    fft_start,      0);
        check("rst_fft_in_zero",  (fft_in === '0), 1);
        reset = 1'b0;

        // Packing: first frame after 8 ticks (4 clk apart)
        wait_start(60, n, found);
        check("first_start_found",  found, 1);
        check("first_start_cycles", n,     33);
        check("pack_frame_7f00",    (fft_in === exp_frame), 1);
        step();
        check("start_one_cycle",    fft_start, 0);

        // Peak scan: status rise sampled at edge T, height_valid only after T+4
        fft_status = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("peak_valid_k%0d", k), height_valid, (k == 4) ? 1 : 0);
            if (k == 4) begin
                check("peak_bin_tie_low", peak_bin,   2);
                check("peak_raw_height",  height,     118);
                check("sil_height",       s_height,   100);
                check("sil_peak_bin",     s_peak_bin, 2);
            end
        end
        fft_status = 1'b0;

        // Overrun: hold status low for 20 ticks after a start
        wait_start(60, n, found);
        check("ovr_start_found", found, 1);
        mic_data = 12'h000;
        repeat (80) step();
        check("ovr_count_2",        overrun_cnt, 2);
        check("ovr_fft_in_kept",    (fft_in === exp_frame), 1);
        fft_status = 1'b1;
        wait_valid(12, found);
        check("ovr_update_found",   found,  1);
        check("ovr_update_height",  height, 118);
        fft_status = 1'b0;
        wait_start(40, n, found);
        check("ovr_back_to_fill",   found,       1);
        check("ovr_count_held",     overrun_cnt, 2);
        check("ovr_new_frame_zero", (fft_in === '0), 1);

        // Reset during SCAN
        fft_status = 1'b1;
        step();
        reset      = 1'b1;
        fft_status = 1'b0;
        step();
        check("rscan_height",  height,       0);
        check("rscan_overrun", overrun_cnt,  0);
        check("rscan_valid",   height_valid, 0);
        reset = 1'b0;
        n = 0;
        pulse_seen = 1'b0;
        do begin
            step();
            n++;
            if (height_valid) pulse_seen = 1'b1;
        end while (!fft_start && n < 60);
        check("rscan_no_valid",     pulse_seen, 0);
        check("rscan_start_found",  fft_start,  1);
        check("rscan_start_cycles", n,          33);

        // Smoothing warm-up over four frames of raw 118 (silent instance: 100)
        smooth_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_start(40, n, found);
                check($sformatf("smooth_start_%0d", i), found, 1);
            end
            fft_status = 1'b1;
            wait_valid(12, found);
            check($sformatf("smooth_valid_%0d", i),  found,    1);
            check($sformatf("smooth_height_%0d", i), height,   exp_smooth[i]);
            check($sformatf("sil_smooth_%0d", i),    s_height, exp_sil[i]);
            fft_status = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
